// File: rtl/sd_cmd_pkg.sv
// rtl/sd_cmd_pkg.sv - shared constants, state encoding and CRC7 step for the SD CMD line
package sd_cmd_pkg;

    localparam int         FRAME_BITS  = 48;
    localparam int         CMD_INDEX_W = 6;
    localparam int         CMD_ARG_W   = 32;
    localparam logic [6:0] CRC7_POLY   = 7'h09;
    localparam logic       TX_BIT      = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        CRC  = 3'd2,
        STOP = 3'd3,
        GAP  = 3'd4
    } state_e;

    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 generator, shared with the CMD response receiver
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc_q <= '0;
        end else if (en) begin
            crc_q <= crc7_next(crc_q, bit_in);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_tx.sv
// rtl/sd_cmd_tx.sv - serializes a 48-bit SD command token onto CMD, then holds the Ncc gap
module sd_cmd_tx
    import sd_cmd_pkg::*;
#(
    parameter int NCC_TICKS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sd_clk_en,
    input  logic                   cmd_start,
    input  logic [CMD_INDEX_W-1:0] cmd_index,
    input  logic [CMD_ARG_W-1:0]   cmd_argument,
    output logic                   busy,
    output logic                   done,
    output logic                   cmd_out,
    output logic                   cmd_oe
);

    localparam logic [5:0] SEND_LAST = 6'(FRAME_BITS - 9);
    localparam logic [5:0] CRC_LAST  = 6'd6;
    localparam logic [5:0] GAP_LAST  = 6'(NCC_TICKS - 1);

    state_e      state_q, state_d;
    logic [39:0] shreg_q, shreg_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cmd_out_q, cmd_out_d;
    logic        cmd_oe_q, cmd_oe_d;
    logic        crc_clr, crc_en;
    logic [6:0]  crc, crc_nx;

    sd_crc7 u_crc7 (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (shreg_q[39]),
        .crc    (crc)
    );

    // The final SEND tick must present crc[6] including the last argument bit.
    assign crc_nx = crc7_next(crc, shreg_q[39]);

    // shreg_q[39] always mirrors the bit currently on the line.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cmd_out_d = cmd_out_q;
        cmd_oe_d  = cmd_oe_q;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    shreg_d   = {1'b0, TX_BIT, cmd_index, cmd_argument};
                    cnt_d     = '0;
                    crc_clr   = 1'b1;
                    busy_d    = 1'b1;
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = 1'b0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (sd_clk_en) begin
                    crc_en = 1'b1;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == SEND_LAST) begin
                        shreg_d   = {crc_nx, 33'd0};
                        cmd_out_d = crc_nx[6];
                        cnt_d     = '0;
                        state_d   = CRC;
                    end else begin
                        shreg_d   = {shreg_q[38:0], 1'b0};
                        cmd_out_d = shreg_q[38];
                    end
                end
            end
            CRC: begin
                if (sd_clk_en) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == CRC_LAST) begin
                        cmd_out_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = STOP;
                    end else begin
                        shreg_d   = {shreg_q[38:0], 1'b0};
                        cmd_out_d = shreg_q[38];
                    end
                end
            end
            STOP: begin
                if (sd_clk_en) begin
                    cmd_oe_d  = 1'b0;
                    cmd_out_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (sd_clk_en) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == GAP_LAST) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cmd_out_q <= 1'b1;
            cmd_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cmd_out_q <= cmd_out_d;
            cmd_oe_q  <= cmd_oe_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cmd_out = cmd_out_q;
    assign cmd_oe  = cmd_oe_q;

endmodule

// File: doc/sd_cmd_tx.md
Name: sd_cmd_tx

Overview:
Command-line transmitter for the SD host. It consumes the Command Index and Command Argument values held in the host register set and serializes a 48-bit SD command token onto the CMD line. The token is start bit, transmission bit, index, argument, CRC7 and end bit. Bits advance at the SD-clock rate, after which the block enforces the inter-command gap and reports completion back to the register/control side.

Parameters:
NCC_TICKS, 8, number of sd_clk_en ticks with the CMD line released (driven high, oe low) after the end bit, before done.
FRAME_BITS, 48, command token length; fixed, not to be overridden.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sd_clk_en  in  1  one-clk strobe per SD clock period; bit-advance tick
cmd_start  in  1  request to send; sampled only when busy=0
cmd_index  in  6  command index, captured on accepted cmd_start
cmd_argument  in  32  command argument, captured on accepted cmd_start
busy  out  1  transmitter owns CMD line or is in gap
done  out  1  one-clk pulse at end of gap
cmd_out  out  1  serial CMD data, MSB first
cmd_oe  out  1  CMD output enable

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- All outputs are registered. Reset values: busy=0, done=0, cmd_out=1, cmd_oe=0; state=IDLE; counters=0; CRC=0.
- States: IDLE, SEND (token bits 47..8), CRC (bits 7..1), STOP (bit 0), GAP.
- IDLE:
  - cmd_start=1 captures cmd_index and cmd_argument into a 40-bit shift register {1'b0, 1'b1, index, argument}.
  - On the next edge: busy=1, cmd_oe=1, cmd_out=0 (start bit), state=SEND.
  - sd_clk_en is ignored in IDLE.
- Bit timing: each bit is held until a clk cycle with sd_clk_en=1. The next bit is presented on that edge. Each bit therefore lasts exactly one tick interval.
- SEND:
  - On each tick, shift the current bit into CRC7 and present the next bit.
  - After 40 ticks, go to CRC and present crc[6].
- CRC7 details:
  - Polynomial x^7+x^3+1, init 0.
  - Computed over bits 47..8 only.
  - Serial update: fb = bit ^ crc[6]; crc = {crc[5:0],0} ^ (fb ? 7'h09 : 0).
- CRC: on each tick, present the next CRC bit (crc[6] down to crc[0]). After 7 ticks go to STOP with cmd_out=1 (end bit).
- STOP: on a tick, go to GAP with cmd_oe=0, cmd_out=1, and gap counter cleared.
- GAP:
  - Count NCC_TICKS ticks.
  - On the edge consuming the last tick: done=1 for that one cycle, busy=0, state=IDLE.
- Busy length: busy stays high for exactly 48+NCC_TICKS ticks after start capture.
- cmd_start rules:
  - Ignored while busy=1; no queueing.
  - cmd_start in the cycle where done=1 is accepted, because busy=0 in that cycle.
- Index/argument changes after capture have no effect on the frame in flight.
- Reset mid-frame or mid-gap: on the next edge all outputs return to reset values with no done pulse. A partial token is abandoned.
- sd_clk_en held constantly 1 is legal and yields one bit per clk.

Decomposition:
- Package sd_cmd_pkg holds:
  - FRAME_BITS=48, CRC7_POLY=7'h09, TX_BIT=1'b1;
  - state enum {IDLE, SEND, CRC, STOP, GAP};
  - field widths CMD_INDEX_W=6, CMD_ARG_W=32.
- Sub-module sd_crc7 is a serial CRC7 generator with ports clk, rst, clr, en, bit_in, crc[6:0]. The CMD response receiver will reuse it.

Test Plan:
1. CMD0: index 0, arg 0x00000000, sd_clk_en=1 constantly -> serial frame 0x40_00000000_95. busy high 56 cycles, done pulses once, cmd_oe high exactly 48 cycles.
2. CMD8: index 8, arg 0x000001AA -> frame 0x48_000001AA_87 (CRC7=0x43).
3. CMD17: index 17, arg 0 with sd_clk_en every 4th clk -> frame 0x51_00000000_55. Each bit held 4 clks; done appears 56 ticks after capture.
4. cmd_start pulsed mid-frame, and cmd_argument changed mid-frame -> frame unchanged, no second transmission. A cmd_start coincident with done starts a new frame on the next edge.
5. Reset asserted at tick 20 of SEND -> next cycle cmd_oe=0, cmd_out=1, busy=0, no done. A subsequent CMD0 is correct (CRC cleared).
6. sd_clk_en pulses while IDLE and cmd_start absent -> cmd_oe stays 0, cmd_out stays 1, busy/done stay 0.
